// File: rtl/bus_fifo_bank.sv
// Bank of per-device TX/RX FIFO pairs between the host and the bus arbiter.
// Each channel is independent and adds occupancy, full/empty flags and saturating error counters.

module bus_fifo_bank_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8,
    localparam int LW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] head,
    output logic             nonempty,
    output logic             full,
    output logic [LW-1:0]    level,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic             udf
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    cnt;
    logic             rd_ok, wr_ok;

    assign nonempty = (cnt != '0);
    assign full     = (cnt == LW'(DEPTH));
    assign level    = cnt;
    assign head     = nonempty ? mem[rd_ptr] : '0;

    // A read frees a slot in the same edge, so a write to a full FIFO is still accepted alongside it.
    assign rd_ok = rd && nonempty;
    assign wr_ok = wr && (!full || rd_ok);
    assign udf   = rd && !nonempty;

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            ovf_cnt <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !rd_ok)
                cnt <= cnt + 1'b1;
            else if (!wr_ok && rd_ok)
                cnt <= cnt - 1'b1;
            if (wr && !wr_ok && ovf_cnt != '1)
                ovf_cnt <= ovf_cnt + 1'b1;
        end
    end
endmodule

module bus_fifo_bank_chan #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int RX_EN = 1,
    parameter int CNT_W = 8,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_wr,
    input  logic [WIDTH-1:0] tx_wdata,
    output logic             tx_full,
    output logic [LW-1:0]    tx_level,
    output logic             pndng,
    output logic [WIDTH-1:0] d_pop,
    input  logic             pop,
    input  logic             push,
    input  logic [WIDTH-1:0] d_push,
    input  logic             rx_rd,
    output logic [WIDTH-1:0] rx_rdata,
    output logic             rx_empty,
    output logic [CNT_W-1:0] tx_ovf_cnt,
    output logic [CNT_W-1:0] rx_ovf_cnt,
    output logic [CNT_W-1:0] udf_cnt
);
    localparam int SW = CNT_W + 1;

    logic          tx_udf, rx_udf;
    logic [SW-1:0] udf_sum;

    bus_fifo_bank_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_tx (
        .clk      (clk),
        .reset    (reset),
        .wr       (tx_wr),
        .wdata    (tx_wdata),
        .rd       (pop),
        .head     (d_pop),
        .nonempty (pndng),
        .full     (tx_full),
        .level    (tx_level),
        .ovf_cnt  (tx_ovf_cnt),
        .udf      (tx_udf)
    );

    generate
        if (RX_EN != 0) begin : g_rx
            logic          rx_nonempty;
            logic          unused_rx_full;
            logic [LW-1:0] unused_rx_level;

            bus_fifo_bank_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_rx (
                .clk      (clk),
                .reset    (reset),
                .wr       (push),
                .wdata    (d_push),
                .rd       (rx_rd),
                .head     (rx_rdata),
                .nonempty (rx_nonempty),
                .full     (unused_rx_full),
                .level    (unused_rx_level),
                .ovf_cnt  (rx_ovf_cnt),
                .udf      (rx_udf)
            );
            assign rx_empty = !rx_nonempty;
        end else begin : g_no_rx
            logic unused_rx_in;
            assign unused_rx_in = ^{push, d_push, rx_rd};
            assign rx_rdata     = '0;
            assign rx_empty     = 1'b1;
            assign rx_ovf_cnt   = '0;
            assign rx_udf       = 1'b0;
        end
    endgenerate

    // Both underflow sources can fire together; the extra sum bit flags saturation.
    assign udf_sum = {1'b0, udf_cnt} + SW'(tx_udf) + SW'(rx_udf);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            udf_cnt <= '0;
        else if (udf_sum[CNT_W])
            udf_cnt <= '1;
        else
            udf_cnt <= udf_sum[CNT_W-1:0];
    end
endmodule

module bus_fifo_bank #(
    parameter int WIDTH = 16,
    parameter int DRVS  = 8,
    parameter int DEPTH = 8,
    parameter int RX_EN = 1,
    parameter int CNT_W = 8,
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DRVS-1:0]       tx_wr,
    input  logic [DRVS*WIDTH-1:0] tx_wdata,
    output logic [DRVS-1:0]       tx_full,
    output logic [DRVS*LW-1:0]    tx_level,
    output logic [DRVS-1:0]       pndng,
    output logic [DRVS*WIDTH-1:0] D_pop,
    input  logic [DRVS-1:0]       pop,
    input  logic [DRVS-1:0]       push,
    input  logic [DRVS*WIDTH-1:0] D_push,
    input  logic [DRVS-1:0]       rx_rd,
    output logic [DRVS*WIDTH-1:0] rx_rdata,
    output logic [DRVS-1:0]       rx_empty,
    output logic [DRVS*CNT_W-1:0] tx_ovf_cnt,
    output logic [DRVS*CNT_W-1:0] rx_ovf_cnt,
    output logic [DRVS*CNT_W-1:0] udf_cnt
);
    genvar c;
    generate
        for (c = 0; c < DRVS; c++) begin : g_chan
            bus_fifo_bank_chan #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .RX_EN (RX_EN),
                .CNT_W (CNT_W)
            ) u_chan (
                .clk        (clk),
                .reset      (reset),
                .tx_wr      (tx_wr[c]),
                .tx_wdata   (tx_wdata[c*WIDTH +: WIDTH]),
                .tx_full    (tx_full[c]),
                .tx_level   (tx_level[c*LW +: LW]),
                .pndng      (pndng[c]),
                .d_pop      (D_pop[c*WIDTH +: WIDTH]),
                .pop        (pop[c]),
                .push       (push[c]),
                .d_push     (D_push[c*WIDTH +: WIDTH]),
                .rx_rd      (rx_rd[c]),
                .rx_rdata   (rx_rdata[c*WIDTH +: WIDTH]),
                .rx_empty   (rx_empty[c]),
                .tx_ovf_cnt (tx_ovf_cnt[c*CNT_W +: CNT_W]),
                .rx_ovf_cnt (rx_ovf_cnt[c*CNT_W +: CNT_W]),
                .udf_cnt    (udf_cnt[c*CNT_W +: CNT_W])
            );
        end
    endgenerate
endmodule

// File: tb/tb_bus_fifo_bank.sv
// Scoreboard bench for bus_fifo_bank: a queue-based model per channel, directed scenarios
// followed by randomized traffic; separate monitors check head data and per-cycle status.

module tb_bus_fifo_bank;
    localparam int WIDTH = 16;
    localparam int DRVS  = 8;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int LW    = 4;
    localparam int MAXC  = 255;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [DRVS-1:0]       tx_wr = '0, pop = '0, push = '0, rx_rd = '0;
    logic [DRVS*WIDTH-1:0] tx_wdata = '0, D_push = '0;
    logic [DRVS-1:0]       tx_full, pndng, rx_empty;
    logic [DRVS*LW-1:0]    tx_level;
    logic [DRVS*WIDTH-1:0] D_pop, rx_rdata;
    logic [DRVS*CNT_W-1:0] tx_ovf_cnt, rx_ovf_cnt, udf_cnt;

    bus_fifo_bank #(.WIDTH(WIDTH), .DRVS(DRVS), .DEPTH(DEPTH), .RX_EN(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_full(tx_full),
        .tx_level(tx_level), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
        .D_push(D_push), .rx_rd(rx_rd), .rx_rdata(rx_rdata), .rx_empty(rx_empty),
        .tx_ovf_cnt(tx_ovf_cnt), .rx_ovf_cnt(rx_ovf_cnt), .udf_cnt(udf_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: queues hold what each FIFO should contain, in order.
    logic [WIDTH-1:0] txq [DRVS][$];
    logic [WIDTH-1:0] rxq [DRVS][$];
    int tx_ovf [DRVS];
    int rx_ovf [DRVS];
    int udf    [DRVS];
    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(string name, int c, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s ch%0d: got 0x%0h expected 0x%0h at %0t", name, c, act, exp, $time);
    endfunction

    function automatic int sat(int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic logic [DRVS*WIDTH-1:0] put(int c, logic [WIDTH-1:0] v);
        logic [DRVS*WIDTH-1:0] r;
        r = '0;
        r[c*WIDTH +: WIDTH] = v;
        return r;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < DRVS; c++) begin
            txq[c].delete();
            rxq[c].delete();
            tx_ovf[c] = 0;
            rx_ovf[c] = 0;
            udf[c]    = 0;
        end
    endfunction

    // Drive one cycle of stimulus and record the outcome the rules predict.
    task automatic cycle(input logic [DRVS-1:0] w, input logic [DRVS-1:0] p,
                         input logic [DRVS-1:0] pu, input logic [DRVS-1:0] r,
                         input logic [DRVS*WIDTH-1:0] wd, input logic [DRVS*WIDTH-1:0] pd);
        @(negedge clk);
        tx_wr = w; pop = p; push = pu; rx_rd = r; tx_wdata = wd; D_push = pd;
        for (int c = 0; c < DRVS; c++) begin
            int  u;
            bit  pok, rok;
            u   = 0;
            pok = p[c] && (txq[c].size() > 0);
            rok = r[c] && (rxq[c].size() > 0);
            if (p[c] && !pok) u++;
            if (r[c] && !rok) u++;
            if (w[c]) begin
                if (txq[c].size() < DEPTH || pok) txq[c].push_back(wd[c*WIDTH +: WIDTH]);
                else tx_ovf[c] = sat(tx_ovf[c] + 1);
            end
            if (pu[c]) begin
                if (rxq[c].size() < DEPTH || rok) rxq[c].push_back(pd[c*WIDTH +: WIDTH]);
                else rx_ovf[c] = sat(rx_ovf[c] + 1);
            end
            udf[c] = sat(udf[c] + u);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '0, '0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tx_wr = '0; pop = '0; push = '0; rx_rd = '0;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Data monitor: whenever the bus pops or the host reads a live head, compare to the next expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int c = 0; c < DRVS; c++) begin
                if (pop[c] && pndng[c]) begin
                    if (txq[c].size() == 0) chk("tx_unexpected_pop", c, 1, 0);
                    else chk("D_pop_order", c, D_pop[c*WIDTH +: WIDTH], txq[c].pop_front());
                end
                if (rx_rd[c] && !rx_empty[c]) begin
                    if (rxq[c].size() == 0) chk("rx_unexpected_read", c, 1, 0);
                    else chk("rx_rdata_order", c, rx_rdata[c*WIDTH +: WIDTH], rxq[c].pop_front());
                end
            end
        end
    end

    // Status monitor: flags, levels, idle heads and counters after every edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < DRVS; c++) begin
                int ts, rs;
                ts = txq[c].size();
                rs = rxq[c].size();
                chk("pndng", c, pndng[c], ts != 0);
                chk("tx_full", c, tx_full[c], ts == DEPTH);
                chk("tx_level", c, tx_level[c*LW +: LW], ts);
                chk("D_pop_head", c, D_pop[c*WIDTH +: WIDTH], ts != 0 ? txq[c][0] : 0);
                chk("rx_empty", c, rx_empty[c], rs == 0);
                chk("rx_rdata_head", c, rx_rdata[c*WIDTH +: WIDTH], rs != 0 ? rxq[c][0] : 0);
                chk("tx_ovf_cnt", c, tx_ovf_cnt[c*CNT_W +: CNT_W], tx_ovf[c]);
                chk("rx_ovf_cnt", c, rx_ovf_cnt[c*CNT_W +: CNT_W], rx_ovf[c]);
                chk("udf_cnt", c, udf_cnt[c*CNT_W +: CNT_W], udf[c]);
            end
        end
    end

    function automatic logic [DRVS*WIDTH-1:0] rnd_data();
        logic [DRVS*WIDTH-1:0] r;
        for (int c = 0; c < DRVS; c++) r[c*WIDTH +: WIDTH] = WIDTH'($urandom);
        return r;
    endfunction

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset mid-stream with three entries queued on ch0.
        for (int i = 0; i < 3; i++) cycle(8'h01, '0, '0, '0, put(0, WIDTH'(16'hA0 + i)), '0);
        do_reset();
        idle(1);

        // Fill, partial drain, refill across the wrap point, full drain.
        for (int i = 1; i <= 8; i++)  cycle(8'h04, '0, '0, '0, put(2, WIDTH'(i)), '0);
        for (int i = 0; i < 4; i++)   cycle('0, 8'h04, '0, '0, '0, '0);
        for (int i = 9; i <= 12; i++) cycle(8'h04, '0, '0, '0, put(2, WIDTH'(i)), '0);
        for (int i = 0; i < 8; i++)   cycle('0, 8'h04, '0, '0, '0, '0);
        idle(1);

        // Overflow on a full FIFO, then a simultaneous write+pop while full.
        for (int i = 0; i < 8; i++) cycle(8'h20, '0, '0, '0, put(5, WIDTH'(16'h50 + i)), '0);
        for (int i = 0; i < 3; i++) cycle(8'h20, '0, '0, '0, put(5, 16'hEEEE), '0);
        cycle(8'h20, 8'h20, '0, '0, put(5, 16'h7777), '0);
        for (int i = 0; i < 8; i++) cycle('0, 8'h20, '0, '0, '0, '0);

        // Underflow saturation on ch1.
        for (int i = 0; i < 300; i++) cycle('0, 8'h02, '0, '0, '0, '0);

        // RX path on ch7.
        cycle('0, '0, 8'h80, '0, '0, put(7, 16'hBEEF));
        cycle('0, '0, 8'h80, '0, '0, put(7, 16'hCAFE));
        cycle('0, '0, '0, 8'h80, '0, '0);
        cycle('0, '0, '0, 8'h80, '0, '0);
        idle(1);

        // Double underflow (pop + read on empty) in one cycle on ch3.
        cycle('0, 8'h08, '0, 8'h08, '0, '0);

        // All channels written and popped every cycle at a steady level.
        for (int i = 0; i < 3; i++) cycle('1, '0, '0, '0, rnd_data(), '0);
        for (int i = 0; i < 100; i++) cycle('1, '1, '0, '0, rnd_data(), '0);
        for (int i = 0; i < 3; i++) cycle('0, '1, '0, '0, '0, '0);

        // Randomized traffic with a reset in the middle.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            logic [DRVS-1:0] w, p, pu, r;
            if (i == 700) do_reset();
            if ((i / 250) % 2 == 0) begin
                w = DRVS'($urandom) | DRVS'($urandom); p = DRVS'($urandom) & DRVS'($urandom);
                pu = DRVS'($urandom) | DRVS'($urandom); r = DRVS'($urandom) & DRVS'($urandom);
            end else begin
                w = DRVS'($urandom) & DRVS'($urandom); p = DRVS'($urandom) | DRVS'($urandom);
                pu = DRVS'($urandom) & DRVS'($urandom); r = DRVS'($urandom) | DRVS'($urandom);
            end
            cycle(w, p, pu, r, rnd_data(), rnd_data());
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
